branch_resolve_unit: RTL

// Multi-lane branch resolution stage for the superscalar core. Each cycle it takes up to LANES

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/branch_cmp_lane.sv | 29 ++
 rtl/branch_resolve_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I branch definitions: funct3 encodings and the branch-type enum used by decode
// and by the branch resolution stage.
package riscv_pkg;

   localparam logic [2:0] BR_BEQ  = 3'd0;
   localparam logic [2:0] BR_BNE  = 3'd1;
   localparam logic [2:0] BR_BLT  = 3'd4;
   localparam logic [2:0] BR_BGE  = 3'd5;
   localparam logic [2:0] BR_BLTU = 3'd6;
   localparam logic [2:0] BR_BGEU = 3'd7;

   typedef enum logic [2:0] {
      BT_BEQ  = BR_BEQ,
      BT_BNE  = BR_BNE,
      BT_RSV2 = 3'd2,
      BT_RSV3 = 3'd3,
      BT_BLT  = BR_BLT,
      BT_BGE  = BR_BGE,
      BT_BLTU = BR_BLTU,
      BT_BGEU = BR_BGEU
   } br_type_t;

endpackage

// File: rtl/branch_cmp_lane.sv
// Combinational RV32I branch condition evaluator for one lane.
// Reserved funct3 encodings resolve not-taken and flag illegal.
module branch_cmp_lane
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      funct3,
   output logic            taken,
   output logic            illegal
);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (br_type_t'(funct3))
         BT_BEQ:  taken = (a == b);
         BT_BNE:  taken = (a != b);
         BT_BLT:  taken = ($signed(a) <  $signed(b));
         BT_BGE:  taken = ($signed(a) >= $signed(b));
         BT_BLTU: taken = (a <  b);
         BT_BGEU: taken = (a >= b);
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Multi-lane branch resolution stage: evaluates each lane, finds the oldest mispredict,
// squashes younger lanes and registers a single redirect plus a saturating mispredict count.
module branch_resolve_unit
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned LANES  = 2,
   parameter int unsigned CNT_W  = 16,
   localparam int unsigned LANE_W = $clog2(LANES) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_in,
   input  logic [LANES-1:0]      in_valid,
   output logic                  in_ready,
   input  logic [LANES*XLEN-1:0] in_a,
   input  logic [LANES*XLEN-1:0] in_b,
   input  logic [LANES*3-1:0]    in_funct3,
   input  logic [LANES*XLEN-1:0] in_pc,
   input  logic [LANES*XLEN-1:0] in_imm,
   input  logic [LANES-1:0]      in_pred_taken,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES-1:0]      out_lane_valid,
   output logic [LANES-1:0]      out_taken,
   output logic [LANES-1:0]      out_illegal,
   output logic                  out_mispredict,
   output logic [LANE_W-1:0]     out_lane,
   output logic [XLEN-1:0]       out_redirect_pc,
   output logic [CNT_W-1:0]      mispredict_count
);

   logic [LANES-1:0]  taken;
   logic [LANES-1:0]  illegal;
   logic              found;
   logic [LANE_W-1:0] mis_lane;
   logic [XLEN-1:0]   redirect_pc;
   logic [LANES-1:0]  lane_valid;
   logic              load;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      branch_cmp_lane #(.XLEN(XLEN)) u_cmp (
         .a       (in_a[g*XLEN +: XLEN]),
         .b       (in_b[g*XLEN +: XLEN]),
         .funct3  (in_funct3[g*3 +: 3]),
         .taken   (taken[g]),
         .illegal (illegal[g])
      );
   end

   // Ascending scan with a found flag: the first hit is the oldest mispredict,
   // and every later valid lane is squashed.
   always_comb begin
      found       = 1'b0;
      mis_lane    = '0;
      redirect_pc = '0;
      lane_valid  = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         lane_valid[i] = in_valid[i] && !found;
         if (!found && in_valid[i] && (taken[i] != in_pred_taken[i])) begin
            found       = 1'b1;
            mis_lane    = LANE_W'(i);
            redirect_pc = taken[i] ? in_pc[i*XLEN +: XLEN] + in_imm[i*XLEN +: XLEN]
                                   : in_pc[i*XLEN +: XLEN] + XLEN'(4);
         end
      end
   end

   assign in_ready = !out_valid || out_ready;
   assign load     = in_ready && (|in_valid) && !flush_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid        <= 1'b0;
         out_lane_valid   <= '0;
         out_taken        <= '0;
         out_illegal      <= '0;
         out_mispredict   <= 1'b0;
         out_lane         <= '0;
         out_redirect_pc  <= '0;
         mispredict_count <= '0;
      end else begin
         if (out_valid && out_ready && out_mispredict && !flush_in && (mispredict_count != '1)) begin
            mispredict_count <= mispredict_count + CNT_W'(1);
         end
         if (flush_in) begin
            out_valid      <= 1'b0;
            out_lane_valid <= '0;
         end else if (load) begin
            out_valid       <= 1'b1;
            out_lane_valid  <= lane_valid;
            out_taken       <= taken;
            out_illegal     <= illegal;
            out_mispredict  <= found;
            out_lane        <= mis_lane;
            out_redirect_pc <= redirect_pc;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
